grid_cell_scheduler: RTL and testbench
======================================

# grid_cell_scheduler

Shares the single-port grid-cell BRAM between the VGA display fetch and a host cell-update writer in the `grid_visualize` design. It sits between the VGA timing generator and the pixel colour logic. Each cycle it grants the memory port to one of three requesters:
- a display read at every cell boundary, which has absolute priority;
- a full-grid clear sweep;
- a ready/valid cell write.

It also delays the sync, blank and count signals so they stay aligned with the returned cell data.

## Interface
Parameters:
- `CELL_SHIFT`, 4, log2 of cell size in pixels (16x16 cells)
- `GRID_COLS`, 40, cells per row
- `GRID_ROWS`, 30, cell rows
- `DATA_WIDTH`, 8, cell data width
- `READ_LATENCY`, 2, BRAM cycles from registered address to valid `mem_dout_in`
- `CLEAR_VALUE`, 0, value written by the clear sweep
- `ADDR_W`, `$clog2(GRID_COLS*GRID_ROWS)`, memory address width

Ports:
- `pixel_clk_in` input 1 — sole clock
- `rst_in` input 1 — synchronous, active-high reset
- `hcount_in` input 11 — pixel number from VGA timing
- `vcount_in` input 10 — line number from VGA timing
- `hsync_in`, `vsync_in`, `blank_in` input 1 each — from VGA timing, aligned with the counts
- `wr_valid_in` input 1 — cell write request
- `wr_col_in` input 6 — write column
- `wr_row_in` input 5 — write row
- `wr_data_in` input `DATA_WIDTH` — write data
- `wr_ready_out` output 1 — write accepted when `wr_valid_in` and `wr_ready_out` are both high
- `clear_in` input 1 — pulse; starts the clear sweep
- `busy_out` output 1 — clear sweep in progress
- `mem_addr_out` output `ADDR_W` — registered BRAM address
- `mem_we_out` output 1 — registered BRAM write enable
- `mem_din_out` output `DATA_WIDTH` — registered BRAM write data
- `mem_dout_in` input `DATA_WIDTH` — BRAM read data
- `cell_data_out` output `DATA_WIDTH` — cell value for the current delayed pixel
- `hcount_out` output 11 — `hcount_in` delayed D
- `vcount_out` output 10 — `vcount_in` delayed D
- `hsync_out`, `vsync_out`, `blank_out` output 1 each — inputs delayed D
- `drop_count_out` output 16 — saturating count of accepted out-of-range writes

D = `READ_LATENCY` + 2.

## Operation
- **Display slot.** `slot = ~blank_in & (hcount_in[CELL_SHIFT-1:0] == 0)`.
  - Address = `(vcount_in>>CELL_SHIFT)*GRID_COLS + (hcount_in>>CELL_SHIFT)`, computed at full `ADDR_W` width.
  - In a slot cycle: `mem_addr_out` is loaded with this address and `mem_we_out` is loaded with 0.
- **FSM states: IDLE, CLEAR.**
  - IDLE: `clear_in` high moves to CLEAR, with `clr_addr` = 0.
  - CLEAR: in each non-slot cycle, write `CLEAR_VALUE` at `clr_addr`, then increment `clr_addr`.
  - After writing address `GRID_COLS*GRID_ROWS-1`, return to IDLE on the next cycle.
  - `clear_in` is ignored while in CLEAR.
  - `busy_out` = (state == CLEAR), registered.
- **Write port.** `wr_ready_out = ~rst_in & ~slot & (state == IDLE) & ~clear_in` (combinational).
  - Accepted in-range write: the next cycle shows `mem_we_out`=1, `mem_addr_out` = `row*GRID_COLS+col`, `mem_din_out` = `wr_data_in`.
  - Out-of-range write (`col >= GRID_COLS` or `row >= GRID_ROWS`): accepted, no memory write issued, `drop_count_out` incremented. It saturates at 0xFFFF.
- **Idle cycles.** A cycle with no grant drives `mem_we_out` = 0 and holds `mem_addr_out`.
- **Priority.** Display slot > clear sweep > host write. Exactly one grant per cycle.
- **Read tag pipeline.** A one-bit tag pipeline (length `READ_LATENCY`+1) marks display reads. When a tag exits, `cell_data_out` <= `mem_dout_in`. Otherwise `cell_data_out` holds its value. Writes never update `cell_data_out`.

## Timing
- **Display read path.**
  - Slot sampled at cycle t.
  - `mem_addr_out` valid at t+1.
  - `mem_dout_in` valid at t+1+`READ_LATENCY`.
  - `cell_data_out` updated at t+2+`READ_LATENCY` = t+D.
  - Result: `cell_data_out` changes exactly when `hcount_out` reaches the cell's first pixel, and holds for the whole cell.
- **Write path.** A write accepted at cycle t drives the memory port at t+1. Its read-after-write visibility is governed by the BRAM.
- **Delay line.** Sync, blank and count are delayed by a D-stage shift register.
- **Reset values** (all held while `rst_in` is high):
  - `hsync_out`, `vsync_out`, `blank_out` = 1
  - `hcount_out`, `vcount_out` = 0
  - `cell_data_out`, `mem_addr_out`, `mem_we_out`, `mem_din_out` = 0
  - `busy_out`, `drop_count_out` = 0
  - `wr_ready_out` = 0
- **Reset mid-clear.** Sweep aborted, FSM to IDLE, tag and delay pipelines flushed to their reset values.
- **`clear_in` and `wr_valid_in` in the same IDLE cycle.** Clear wins; the write is not accepted.
- **Sweep duration.** A clear during active video takes `GRID_COLS*GRID_ROWS` plus the skipped slot cycles. Slots are never delayed.

## Test plan
1. **Reset.** Hold `rst_in` 3 cycles → every output equals its reset value; `wr_ready_out`=0 despite `wr_valid_in`=1.
2. **Write then display.** Write during blank: col 3, row 2, data 0xA5.
   - Next cycle: `mem_we_out`=1, `mem_addr_out`=83, `mem_din_out`=0xA5.
   - Next frame: `cell_data_out`=0xA5 while `hcount_out` is 48..63 and `vcount_out` is 32..47.
3. **Slot collision.** `wr_valid_in` held at `hcount_in`=16 during active video.
   - `wr_ready_out`=0 at hcount 16.
   - Accepted at hcount 17; write on the port at hcount 18.
   - Display read at the hcount-16 slot is unaffected.
4. **Out-of-range write.** col 40, row 0 → accepted, `mem_we_out` stays 0, `drop_count_out`=1.
   - With `drop_count_out` preloaded to 0xFFFF by 65535 drops: one more drop leaves it at 0xFFFF.
5. **Clear sweep.** Pulse `clear_in` during active video.
   - `busy_out`=1 next cycle.
   - 1200 writes of `CLEAR_VALUE`, addresses 0..1199 in order, none in a slot cycle.
   - `wr_ready_out`=0 throughout; `busy_out`=0 one cycle after address 1199.
6. **Reset mid-clear.** Assert `rst_in` after 500 clear writes → IDLE, `busy_out`=0.
   - A new `clear_in` restarts the sweep from address 0.

Source files
------------

// File: rtl/grid_cell_scheduler.sv
// grid_cell_scheduler: arbitrates the single-port grid-cell BRAM between the
// VGA display fetch (absolute priority), a full-grid clear sweep and a
// ready/valid host cell writer. It also delays the VGA timing signals so they
// line up with the cell data returned by the memory.
module grid_cell_scheduler #(
    parameter int                    CELL_SHIFT   = 4,
    parameter int                    GRID_COLS    = 40,
    parameter int                    GRID_ROWS    = 30,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
    parameter int                    ADDR_W       = $clog2(GRID_COLS*GRID_ROWS)
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blank_in,
    input  logic                  wr_valid_in,
    input  logic [5:0]            wr_col_in,
    input  logic [4:0]            wr_row_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  wr_ready_out,
    input  logic                  clear_in,
    output logic                  busy_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic                  mem_we_out,
    output logic [DATA_WIDTH-1:0] mem_din_out,
    input  logic [DATA_WIDTH-1:0] mem_dout_in,
    output logic [DATA_WIDTH-1:0] cell_data_out,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  blank_out,
    output logic [15:0]           drop_count_out
);

    // Total pipeline depth from a sampled pixel to its cell data.
    localparam int DELAY = READ_LATENCY + 2;
    localparam int VID_W = 11 + 10 + 3;
    // Reset image of the delay line: counts zero, sync and blank inactive-high.
    localparam logic [VID_W-1:0] VID_RST = {11'd0, 10'd0, 3'b111};

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_COLS*GRID_ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(GRID_COLS);
    localparam logic [5:0]        COLS_LIM  = 6'(GRID_COLS);
    localparam logic [4:0]        ROWS_LIM  = 5'(GRID_ROWS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]            state_reg, state_next;
    logic [ADDR_W-1:0]     clr_addr_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  we_reg;
    logic [DATA_WIDTH-1:0] din_reg;
    logic [15:0]           drop_reg;
    logic                  busy_reg;
    logic [READ_LATENCY:0] tag_reg;
    logic [DATA_WIDTH-1:0] cell_reg;
    logic [VID_W-1:0]      vid_reg [0:DELAY-1];

    logic                  slot;
    logic [ADDR_W-1:0]     disp_row, disp_col, disp_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  wr_in_range;
    logic                  wr_ready;
    logic                  wr_fire;

    // Slot detection, address arithmetic and the host write handshake.
    always_comb begin
        slot        = ~blank_in & (hcount_in[CELL_SHIFT-1:0] == '0);
        disp_row    = ADDR_W'(vcount_in >> CELL_SHIFT);
        disp_col    = ADDR_W'(hcount_in >> CELL_SHIFT);
        disp_addr   = disp_row * COLS_A + disp_col;
        wr_addr     = ADDR_W'(wr_row_in) * COLS_A + ADDR_W'(wr_col_in);
        wr_in_range = (wr_col_in < COLS_LIM) && (wr_row_in < ROWS_LIM);
        // A pending clear request blocks the write so the clear always wins.
        wr_ready    = ~rst_in & ~slot & (state_reg == ST_IDLE) & ~clear_in;
        wr_fire     = wr_valid_in & wr_ready;
    end

    // Sweep FSM: leaves CLEAR only once the last cell write has been granted.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (clear_in) state_next = ST_CLEAR;
        end else begin
            if (~slot && (clr_addr_reg == LAST_ADDR)) state_next = ST_IDLE;
        end
    end

    // Memory port grant (display > clear > host), FSM state and drop counter.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            clr_addr_reg <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            din_reg      <= '0;
            drop_reg     <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_CLEAR);
            we_reg    <= 1'b0;
            if (slot) begin
                addr_reg <= disp_addr;
            end else if (state_reg == ST_CLEAR) begin
                addr_reg     <= clr_addr_reg;
                we_reg       <= 1'b1;
                din_reg      <= CLEAR_VALUE;
                clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
            end else if (wr_fire) begin
                if (wr_in_range) begin
                    addr_reg <= wr_addr;
                    we_reg   <= 1'b1;
                    din_reg  <= wr_data_in;
                end else if (drop_reg != 16'hFFFF) begin
                    drop_reg <= drop_reg + 16'd1;
                end
            end
            // Every sweep starts from the first cell.
            if ((state_reg == ST_IDLE) && clear_in) begin
                clr_addr_reg <= '0;
            end
        end
    end

    // Tag pipeline marks which returning memory words are display reads.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            tag_reg  <= '0;
            cell_reg <= '0;
        end else begin
            tag_reg[0] <= slot;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            if (tag_reg[READ_LATENCY]) begin
                cell_reg <= mem_dout_in;
            end
        end
    end

    // Timing delay line keeps counts and syncs aligned with cell_data_out.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DELAY; i++) begin
                vid_reg[i] <= VID_RST;
            end
        end else begin
            vid_reg[0] <= {hcount_in, vcount_in, hsync_in, vsync_in, blank_in};
            for (int i = 1; i < DELAY; i++) begin
                vid_reg[i] <= vid_reg[i-1];
            end
        end
    end

    assign wr_ready_out   = wr_ready;
    assign busy_out       = busy_reg;
    assign mem_addr_out   = addr_reg;
    assign mem_we_out     = we_reg;
    assign mem_din_out    = din_reg;
    assign cell_data_out  = cell_reg;
    assign drop_count_out = drop_reg;
    assign hcount_out     = vid_reg[DELAY-1][23:13];
    assign vcount_out     = vid_reg[DELAY-1][12:3];
    assign hsync_out      = vid_reg[DELAY-1][2];
    assign vsync_out      = vid_reg[DELAY-1][1];
    assign blank_out      = vid_reg[DELAY-1][0];

endmodule

// File: tb/tb_grid_cell_scheduler.sv
// tb_grid_cell_scheduler: directed test of grid_cell_scheduler against a
// behavioural two-cycle-latency BRAM, with hand-derived expectations.
module tb_grid_cell_scheduler;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic        wr_valid_in;
    logic [5:0]  wr_col_in;
    logic [4:0]  wr_row_in;
    logic [7:0]  wr_data_in;
    logic        wr_ready_out;
    logic        clear_in;
    logic        busy_out;
    logic [10:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_din_out;
    logic [7:0]  mem_dout_in;
    logic [7:0]  cell_data_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [15:0] drop_count_out;

    int n_cmp = 0;
    int n_err = 0;
    bit cleared = 1'b0;
    int vh = 0;
    int vv = 0;

    always #5 clk = ~clk;

    grid_cell_scheduler dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .blank_in       (blank_in),
        .wr_valid_in    (wr_valid_in),
        .wr_col_in      (wr_col_in),
        .wr_row_in      (wr_row_in),
        .wr_data_in     (wr_data_in),
        .wr_ready_out   (wr_ready_out),
        .clear_in       (clear_in),
        .busy_out       (busy_out),
        .mem_addr_out   (mem_addr_out),
        .mem_we_out     (mem_we_out),
        .mem_din_out    (mem_din_out),
        .mem_dout_in    (mem_dout_in),
        .cell_data_out  (cell_data_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_out      (blank_out),
        .drop_count_out (drop_count_out)
    );

    // Single-port BRAM, read-first, registered address plus one output register.
    logic [7:0] mem [0:2047];
    logic [7:0] rd1 = 8'd0;
    logic [7:0] rd2 = 8'd0;
    always @(posedge clk) begin
        if (mem_we_out) mem[mem_addr_out] <= mem_din_out;
        rd1 <= mem[mem_addr_out];
        rd2 <= rd1;
    end
    assign mem_dout_in = rd2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_cell(input int col, input int row);
        if (cleared) return 8'h00;
        if (col == 3 && row == 2) return 8'hA5;
        if (col == 1 && row == 6) return 8'h5A;
        if (col == 10 && row == 10) return 8'h3C;
        return 8'h00;
    endfunction

    function automatic int disp_addr(input int h, input int v);
        return (v / 16) * 40 + (h / 16);
    endfunction

    // Host write issued during blanking; expects acceptance in this cycle.
    task automatic blank_write(input int c, input int r, input logic [7:0] d);
        hcount_in = 11'd700; blank_in = 1'b1; hsync_in = 1'b1;
        wr_col_in = 6'(c); wr_row_in = 5'(r); wr_data_in = d; wr_valid_in = 1'b1;
        #1;
        check_val("ready_blank", 32'(wr_ready_out), 32'd1);
        step();
        wr_valid_in = 1'b0;
        $display("write col %0d row %0d data 0x%0h: we=%0b addr=%0d drops=%0d",
                 c, r, d, mem_we_out, mem_addr_out, drop_count_out);
    endtask

    // One 80-pixel active line plus 8 blank pixels; optional write held at h=16,17.
    task automatic drive_line(input int v, input bit inj, input int c, input int r, input logic [7:0] d);
        for (int h = 0; h < 88; h++) begin
            hcount_in = 11'(h); vcount_in = 10'(v);
            blank_in = (h >= 80); hsync_in = (h < 80); vsync_in = 1'b1;
            if (inj) begin
                wr_valid_in = (h == 16 || h == 17);
                wr_col_in = 6'(c); wr_row_in = 5'(r); wr_data_in = d;
            end
            #1;
            if (inj && h == 16) check_val("ready_at_slot", 32'(wr_ready_out), 32'd0);
            if (inj && h == 17) check_val("ready_after_slot", 32'(wr_ready_out), 32'd1);
            step();
            if (inj && h == 16) begin
                check_val("slot_we", 32'(mem_we_out), 32'd0);
                check_val("slot_addr", 32'(mem_addr_out), 32'(disp_addr(16, v)));
            end
            if (inj && h == 17) begin
                check_val("coll_we", 32'(mem_we_out), 32'd1);
                check_val("coll_addr", 32'(mem_addr_out), 32'(r * 40 + c));
                check_val("coll_din", 32'(mem_din_out), 32'(d));
            end
            if (h >= 3 && h - 3 < 80) begin
                check_val("hcount_out", 32'(hcount_out), 32'(h - 3));
                check_val("vcount_out", 32'(vcount_out), 32'(v));
                check_val("blank_act", 32'(blank_out), 32'd0);
                check_val("hsync_act", 32'(hsync_out), 32'd1);
                check_val("cell_data", 32'(cell_data_out), 32'(exp_cell((h - 3) / 16, v / 16)));
            end else if (h >= 3) begin
                check_val("blank_fill", 32'(blank_out), 32'd1);
            end
        end
        wr_valid_in = 1'b0;
        $display("line v=%0d done", v);
    endtask

    // Pulse clear during continuous video and track clear writes until stop_after.
    task automatic run_sweep(input int stop_after);
        int  nw;
        bit  cyc_slot;
        int  cyc_h, cyc_v;
        nw = 0;
        wr_valid_in = 1'b0;
        clear_in = 1'b1;
        for (int budget = 0; budget < 4000 && nw < stop_after; budget++) begin
            cyc_h = vh; cyc_v = vv;
            hcount_in = 11'(vh); vcount_in = 10'(vv);
            blank_in = (vh >= 80); hsync_in = (vh < 80); vsync_in = 1'b1;
            cyc_slot = (vh < 80) && (vh % 16 == 0);
            #1;
            check_val("ready_in_clear", 32'(wr_ready_out), 32'd0);
            step();
            clear_in = 1'b0;
            if (budget == 0) check_val("busy_start", 32'(busy_out), 32'd1);
            if (cyc_slot) begin
                check_val("sweep_slot_we", 32'(mem_we_out), 32'd0);
                check_val("sweep_slot_addr", 32'(mem_addr_out), 32'(disp_addr(cyc_h, cyc_v)));
            end else if (budget == 0) begin
                check_val("clear_req_we", 32'(mem_we_out), 32'd0);
            end else begin
                check_val("clr_we", 32'(mem_we_out), 32'd1);
                check_val("clr_addr", 32'(mem_addr_out), 32'(nw));
                check_val("clr_din", 32'(mem_din_out), 32'd0);
                nw++;
            end
            vh = (vh == 87) ? 0 : vh + 1;
            if (vh == 0) vv = (vv == 479) ? 0 : vv + 1;
        end
        if (nw < stop_after) check_val("sweep_timeout", 32'(nw), 32'(stop_after));
        $display("clear sweep: %0d writes observed", nw);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // Reset with non-idle inputs to show outputs ignore them.
        rst_in = 1'b1; hcount_in = 11'd5; vcount_in = 10'd7;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        wr_valid_in = 1'b1; wr_col_in = 6'd3; wr_row_in = 5'd2; wr_data_in = 8'hA5;
        clear_in = 1'b0;
        repeat (3) step();
        check_val("rst_hsync", 32'(hsync_out), 32'd1);
        check_val("rst_vsync", 32'(vsync_out), 32'd1);
        check_val("rst_blank", 32'(blank_out), 32'd1);
        check_val("rst_hcount", 32'(hcount_out), 32'd0);
        check_val("rst_vcount", 32'(vcount_out), 32'd0);
        check_val("rst_cell", 32'(cell_data_out), 32'd0);
        check_val("rst_addr", 32'(mem_addr_out), 32'd0);
        check_val("rst_we", 32'(mem_we_out), 32'd0);
        check_val("rst_din", 32'(mem_din_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_drop", 32'(drop_count_out), 32'd0);
        check_val("rst_ready", 32'(wr_ready_out), 32'd0);
        $display("reset released");
        rst_in = 1'b0; wr_valid_in = 1'b0;
        hcount_in = 11'd700; vcount_in = 10'd0; blank_in = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        step();

        // Write during blank, then display it.
        blank_write(3, 2, 8'hA5);
        check_val("wr_we", 32'(mem_we_out), 32'd1);
        check_val("wr_addr", 32'(mem_addr_out), 32'd83);
        check_val("wr_din", 32'(mem_din_out), 32'hA5);
        step();
        check_val("idle_we", 32'(mem_we_out), 32'd0);
        check_val("idle_addr_hold", 32'(mem_addr_out), 32'd83);
        blank_write(1, 6, 8'h5A);
        check_val("wr2_addr", 32'(mem_addr_out), 32'd241);
        drive_line(32, 1'b0, 0, 0, 8'h00);
        drive_line(40, 1'b0, 0, 0, 8'h00);

        // Write colliding with a display slot.
        drive_line(100, 1'b1, 10, 10, 8'h3C);

        // Out-of-range writes are accepted and counted.
        blank_write(40, 0, 8'h11);
        check_val("oor_col_we", 32'(mem_we_out), 32'd0);
        check_val("oor_col_drop", 32'(drop_count_out), 32'd1);
        blank_write(0, 30, 8'h22);
        check_val("oor_row_we", 32'(mem_we_out), 32'd0);
        check_val("oor_row_drop", 32'(drop_count_out), 32'd2);

        // Full clear sweep during active video.
        vh = 5; vv = 0;
        run_sweep(1200);
        step();
        check_val("busy_end", 32'(busy_out), 32'd0);
        check_val("after_sweep_we", 32'(mem_we_out), 32'd0);
        cleared = 1'b1;
        drive_line(32, 1'b0, 0, 0, 8'h00);

        // Reset in the middle of a sweep, then restart from address 0.
        run_sweep(500);
        rst_in = 1'b1;
        step();
        step();
        check_val("midrst_busy", 32'(busy_out), 32'd0);
        check_val("midrst_we", 32'(mem_we_out), 32'd0);
        check_val("midrst_drop", 32'(drop_count_out), 32'd0);
        check_val("midrst_ready", 32'(wr_ready_out), 32'd0);
        rst_in = 1'b0;
        run_sweep(1200);
        step();
        check_val("busy_end2", 32'(busy_out), 32'd0);

        // Drop counter saturation.
        hcount_in = 11'd700; blank_in = 1'b1; hsync_in = 1'b1;
        wr_col_in = 6'd40; wr_row_in = 5'd0; wr_valid_in = 1'b1;
        repeat (65535) step();
        check_val("drop_full", 32'(drop_count_out), 32'hFFFF);
        step();
        check_val("drop_sat", 32'(drop_count_out), 32'hFFFF);
        check_val("drop_sat_we", 32'(mem_we_out), 32'd0);
        wr_valid_in = 1'b0;
        $display("drop counter saturation done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
